chronocube_vram_arbiter: RTL
============================

# chronocube_vram_arbiter

Parametrised VRAM access arbiter that replaces the static two-way MPU/renderer VRAM mux with an N-client request/grant front end. It sits between the VRAM clients (renderer fetch, MPU window, future DMA/blitter) and the external VRAM pins. It issues at most one access per cycle with registered pin outputs, and routes read data back to the issuing client through a tag pipeline. It also inserts bus-turnaround idle cycles when a write follows a read.

## Interface
- NUM_CLIENTS, 2, number of requesters (1..8); client 0 is the renderer by convention
- ADDR_WIDTH, 16, VRAM word-address width
- DATA_WIDTH, 16, VRAM data width
- BE_WIDTH, 2, byte-enable width
- READ_LATENCY, 1, cycles from registered vram_rd to valid vram_data_in (1..4)
- FIXED_PRIORITY, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
- TURNAROUND, 1, idle cycles forced between a read issue and a following write issue (0..3)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NUM_CLIENTS  per-client request, held until granted
- req_wr  in  NUM_CLIENTS  1 = write, 0 = read
- req_be  in  NUM_CLIENTS*BE_WIDTH  flattened byte enables, active-high
- req_addr  in  NUM_CLIENTS*ADDR_WIDTH  flattened word addresses
- req_wdata  in  NUM_CLIENTS*DATA_WIDTH  flattened write data
- gnt  out  NUM_CLIENTS  one-hot accept; the access is taken in the cycle where req&gnt
- rvalid  out  NUM_CLIENTS  one-hot, one-cycle pulse marking read data for that client
- rdata  out  DATA_WIDTH  read data, shared by all clients, qualified by rvalid
- vram_en, vram_rd, vram_wr  out  1 each  registered strobes, active-high
- vram_be  out  BE_WIDTH  registered byte enables, active-high
- vram_addr  out  ADDR_WIDTH  registered address
- vram_data_out  out  DATA_WIDTH  registered write data; 0 when not writing
- vram_data_in  in  DATA_WIDTH  read data from VRAM
- Flattened client i occupies bits [(i+1)*W-1 : i*W].

## Operation
- Arbitration:
  - gnt is combinational from req, the priority pointer `ptr` and the turnaround counter.
  - At most one gnt bit is high. gnt is only ever high where req is high.
- Round-robin: search starts at `ptr`. After a grant to client k, `ptr` <= (k+1) mod NUM_CLIENTS. With no grant, `ptr` holds.
- Fixed priority: the lowest-index requester wins; `ptr` is unused.
- Turnaround:
  - `ta_cnt` loads TURNAROUND on a read grant and decrements to 0 each cycle.
  - While `ta_cnt` != 0, write requests are masked out of arbitration; reads remain eligible.
  - A write grant leaves `ta_cnt` unchanged.
- Issue: in the cycle after a grant, the pins carry that client's command.
  - Read: vram_en=1, vram_rd=1, vram_wr=0.
  - Write: vram_en=1, vram_wr=1, vram_rd=0.
  - vram_addr and vram_be take the client's values.
  - vram_data_out carries wdata only for writes.
  - Cycles with no grant drive en/rd/wr/be/data_out to 0. vram_addr holds its last value.
- Read return: a tag pipeline of depth READ_LATENCY+1 carries {valid, client index}.
  - At the output, rdata <= vram_data_in.
  - rvalid[tag] pulses in the same cycle that rdata updates.
  - Reads return in issue order; rvalid is never back-pressured.
- Writes produce no response.
- Illegal parameters (NUM_CLIENTS=0 or >8, READ_LATENCY=0) must be caught by an elaboration-time check.

## Timing
- Reset values:
  - gnt=0 and rvalid=0, since no req is recognised during reset.
  - rdata=0.
  - All vram_* outputs=0, including vram_addr.
  - ptr=0, ta_cnt=0, all tags invalid.
- Latency:
  - Grant at cycle N.
  - Pins valid at N+1.
  - vram_data_in sampled at N+1+READ_LATENCY.
  - rvalid/rdata at N+2+READ_LATENCY.
- Throughput: one access per cycle, back-to-back, from any mix of clients. The only exception is the read-to-write turnaround.
- Simultaneous requests: exactly one grant per cycle. Losers keep req high and are retried the next cycle.
- Reset asserted mid-operation: all in-flight read tags are discarded (no rvalid for them), and pins return to 0 in the next cycle.
- req deasserted before grant: legal, and no access occurs.
- Changing req_* fields while req=1 and gnt=0: legal. The fields are sampled only in the grant cycle.

## Configuration
- CHRONOCUBE_VRAM_LOCK_EN, when defined:
  - Adds the inputs lock (1 bit) and lock_client ($clog2(NUM_CLIENTS) bits).
  - While lock=1, only lock_client is eligible and `ptr` does not advance. This reproduces exclusive MPU-only VRAM access (MEM_CTRL bit 0 behaviour).
  - A lock asserted with reads in flight does not cancel them.
- When undefined: neither port exists, and all clients always compete.

## Test plan
- Single read:
  - Setup: NUM_CLIENTS=2, READ_LATENCY=1; client 1 reads addr 0x1234; VRAM model returns 0xBEEF.
  - Required: gnt[1] at N; vram_rd=1 and vram_addr=0x1234 at N+1; rvalid=2'b10 and rdata=0xBEEF at N+3.
- Round-robin fairness:
  - Setup: 4 clients all requesting reads continuously, TURNAROUND=0.
  - Required: grant order 0,1,2,3,0,1…; no client gets two grants within 4 cycles.
- Turnaround:
  - Setup: client 0 read and client 1 write both pending, TURNAROUND=2.
  - Required: read granted at N; write granted at N+3; pins idle at N+2 and N+3.
- Fixed priority:
  - Setup: FIXED_PRIORITY=1; clients 0 and 2 requesting continuously.
  - Required: client 0 granted every cycle; client 2 is never granted until req[0] drops.
- Reset mid-read:
  - Setup: READ_LATENCY=3; reset asserted at N+2 after a read grant at N.
  - Required: no rvalid ever pulses for that read; all vram_* outputs are 0 at N+3.
- Lock (with CHRONOCUBE_VRAM_LOCK_EN):
  - Setup: lock=1, lock_client=1; clients 0 and 1 both requesting.
  - Required: only gnt[1] fires while lock=1; ptr unchanged; after lock drops, client 0 is granted on the next cycle.

Source files
------------

// File: rtl/chronocube_vram_arbiter_if.sv
// Client-side request/grant/read-return bundle for chronocube_vram_arbiter.
// master = VRAM client side, slave = arbiter side.
interface chronocube_vram_arbiter_if #(
  parameter int NUM_CLIENTS = 2,
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int BE_WIDTH    = 2
);
  logic [NUM_CLIENTS-1:0]            req;
  logic [NUM_CLIENTS-1:0]            req_wr;
  logic [NUM_CLIENTS*BE_WIDTH-1:0]   req_be;
  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_CLIENTS-1:0]            gnt;
  logic [NUM_CLIENTS-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]             rdata;

  modport master (
    output req, req_wr, req_be, req_addr, req_wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, req_wr, req_be, req_addr, req_wdata,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/chronocube_vram_arbiter.sv
// N-client VRAM arbiter: comb grant, pins one cycle later, rvalid READ_LATENCY+2 after grant; rvalid never stalls.
// Define CHRONOCUBE_VRAM_LOCK_EN to add lock/lock_client exclusive-access inputs.
module chronocube_vram_arbiter #(
  parameter int NUM_CLIENTS    = 2,
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int BE_WIDTH       = 2,
  parameter int READ_LATENCY   = 1,
  parameter int FIXED_PRIORITY = 0,
  parameter int TURNAROUND     = 1,
  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  chronocube_vram_arbiter_if.slave cli,
`ifdef CHRONOCUBE_VRAM_LOCK_EN
  input  logic                    lock,
  input  logic [IDX_W-1:0]        lock_client,
`endif
  output logic                    vram_en,
  output logic                    vram_rd,
  output logic                    vram_wr,
  output logic [BE_WIDTH-1:0]     vram_be,
  output logic [ADDR_WIDTH-1:0]   vram_addr,
  output logic [DATA_WIDTH-1:0]   vram_data_out,
  input  logic [DATA_WIDTH-1:0]   vram_data_in
);

  if (NUM_CLIENTS < 1 || NUM_CLIENTS > 8 || READ_LATENCY < 1 || READ_LATENCY > 4 ||
      TURNAROUND < 0 || TURNAROUND > 3) begin : g_bad_param
    $error("chronocube_vram_arbiter: illegal parameter set");
  end

  logic [IDX_W-1:0]       ptr;
  logic [1:0]             ta_cnt;
  logic [NUM_CLIENTS-1:0] elig;
  logic                   locked;
  logic                   gnt_any;
  logic [IDX_W-1:0]       gnt_idx;
  logic [IDX_W-1:0]       cand_idx;
  logic                   sel_wr;
  logic [BE_WIDTH-1:0]    sel_be;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0]  sel_wdata;
  logic [READ_LATENCY:0]  tag_vld;
  logic [IDX_W-1:0]       tag_idx [READ_LATENCY+1];

  // Writes sit out while the bus is still turning around from a read.
  always_comb begin
    elig = cli.req & ~(cli.req_wr & {NUM_CLIENTS{ta_cnt != 2'd0}}) & {NUM_CLIENTS{~reset}};
`ifdef CHRONOCUBE_VRAM_LOCK_EN
    if (lock) elig = elig & (NUM_CLIENTS'(1) << lock_client);
`endif
  end

`ifdef CHRONOCUBE_VRAM_LOCK_EN
  assign locked = lock;
`else
  assign locked = 1'b0;
`endif

  // Walk the search order backwards so the last hit is the first candidate.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
      if (FIXED_PRIORITY != 0) cand_idx = IDX_W'(k);
      else                     cand_idx = IDX_W'((int'(ptr) + k) % NUM_CLIENTS);
      if (elig[cand_idx]) begin
        gnt_any = 1'b1;
        gnt_idx = cand_idx;
      end
    end
  end

  assign cli.gnt   = gnt_any ? (NUM_CLIENTS'(1) << gnt_idx) : '0;
  assign sel_wr    = cli.req_wr[gnt_idx];
  assign sel_be    = cli.req_be[int'(gnt_idx)*BE_WIDTH +: BE_WIDTH];
  assign sel_addr  = cli.req_addr[int'(gnt_idx)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_wdata = cli.req_wdata[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr           <= '0;
      ta_cnt        <= 2'd0;
      vram_en       <= 1'b0;
      vram_rd       <= 1'b0;
      vram_wr       <= 1'b0;
      vram_be       <= '0;
      vram_addr     <= '0;
      vram_data_out <= '0;
      tag_vld       <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) tag_idx[i] <= '0;
      cli.rvalid    <= '0;
      cli.rdata     <= '0;
    end else begin
      if (FIXED_PRIORITY == 0 && gnt_any && !locked)
        ptr <= (int'(gnt_idx) == NUM_CLIENTS - 1) ? '0 : gnt_idx + 1'b1;

      if (gnt_any && !sel_wr)  ta_cnt <= 2'(TURNAROUND);
      else if (ta_cnt != 2'd0) ta_cnt <= ta_cnt - 2'd1;

      vram_en       <= gnt_any;
      vram_rd       <= gnt_any & ~sel_wr;
      vram_wr       <= gnt_any & sel_wr;
      vram_be       <= gnt_any ? sel_be : '0;
      vram_data_out <= (gnt_any && sel_wr) ? sel_wdata : '0;
      if (gnt_any) vram_addr <= sel_addr;

      // Stage 0 lines up with the pin cycle; stage READ_LATENCY with valid data.
      tag_vld[0] <= gnt_any & ~sel_wr;
      tag_idx[0] <= gnt_idx;
      for (int i = 1; i <= READ_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
        tag_idx[i] <= tag_idx[i-1];
      end

      cli.rvalid <= tag_vld[READ_LATENCY] ? (NUM_CLIENTS'(1) << tag_idx[READ_LATENCY]) : '0;
      if (tag_vld[READ_LATENCY]) cli.rdata <= vram_data_in;
    end
  end

endmodule
